// File: rtl/dist_sq_pkg.sv
// Shared definitions for the dist_sq block (sum of squares a*a + b*b).
// Contents:
//   state_t        control states IDLE, MUL_A, MUL_B, DONE
//   W_DEFAULT      default operand width (signed a, b)
//   OUT_W_DEFAULT  default result width, sized for the downstream Sqrt x input
//   SAT_MAX        saturated result value, 2^OUT_W_DEFAULT - 1
package dist_sq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_A = 2'd1,
    MUL_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int W_DEFAULT     = 11;
  localparam int OUT_W_DEFAULT = 21;

  localparam logic [OUT_W_DEFAULT-1:0] SAT_MAX = {OUT_W_DEFAULT{1'b1}};

endpackage

// File: rtl/dist_sq_sq_serial.sv
// sq_serial: W-cycle shift-add squarer for an unsigned W-bit magnitude.
// It does not own the accumulator; every active cycle it presents the
// partial product for one multiplier bit on 'addend' and the caller adds it
// into its own running sum, so one instance can square several operands
// into a shared accumulator.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   start     begin squaring 'op'; this cycle already processes bit 0
//   op        unsigned magnitude to square, sampled only while start=1
//   busy      a squaring is in progress after its start cycle
//   done      high in the cycle that processes the last (W-th) bit
//   addend    partial product for the bit processed this cycle, else 0
module sq_serial #(
  parameter int W     = 11,
  parameter int ACC_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     op,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] addend
);

  localparam int CNT_W = $clog2(W + 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;

  logic             active;
  logic [CNT_W-1:0] cur_cnt;
  logic [ACC_W-1:0] cur_mcand;
  logic [W-1:0]     cur_mplier;

  // On the start cycle the operand is used directly instead of the registers,
  // so exactly W cycles (start plus W-1 busy cycles) cover all W bits.
  always_comb begin
    active     = start | busy_q;
    cur_cnt    = start ? '0 : cnt_q;
    cur_mcand  = start ? {{(ACC_W-W){1'b0}}, op} : mcand_q;
    cur_mplier = start ? op : mplier_q;

    addend = (active && cur_mplier[0]) ? cur_mcand : '0;
    done   = active && (cur_cnt == CNT_W'(W - 1));

    busy_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (active) begin
      busy_d   = !done;
      cnt_d    = cur_cnt + 1'b1;
      mcand_d  = cur_mcand << 1;
      mplier_d = cur_mplier >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/dist_sq.sv
// dist_sq: serial sum of squares y = a*a + b*b, saturated to 2^OUT_W-1.
// One pair is accepted in IDLE, |a|^2 is accumulated over W cycles (MUL_A),
// |b|^2 over the next W cycles (MUL_B), and the result is held in DONE until
// the downstream stage takes it. y feeds the Sqrt x input directly.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid, in_ready   operand handshake (in_ready only in IDLE)
//   a, b                 signed W-bit operands, sampled on the accepting edge
//   out_valid, out_ready result handshake (out_valid only in DONE)
//   y                    saturated sum of squares
//   sat                  y was saturated
module dist_sq
  import dist_sq_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int OUT_W = OUT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    y,
  output logic                sat
);

  // One spare bit above OUT_W lets the true sum (up to 2^(2W-1)) be compared
  // against 2^OUT_W without wrapping.
  localparam int ACC_W = OUT_W + 1;

  state_t           state_q, state_d;
  logic [W-1:0]     mag_a_q, mag_a_d;
  logic [W-1:0]     mag_b_q, mag_b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] sum;

  logic             sq_start, sq_busy, sq_done;
  logic [W-1:0]     sq_op;
  logic [ACC_W-1:0] sq_addend;

  // Treating the W-bit result as unsigned makes -2^(W-1) map to 2^(W-1).
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    return v[W-1] ? (~v + 1'b1) : v;
  endfunction

  // The squarer is kicked off on the first cycle of each multiply state,
  // which is exactly when it is not already busy.
  assign sq_start = ((state_q == MUL_A) || (state_q == MUL_B)) && !sq_busy;
  assign sq_op    = (state_q == MUL_A) ? mag_a_q : mag_b_q;

  sq_serial #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_sq (
    .clk    (clk),
    .rst    (rst),
    .start  (sq_start),
    .op     (sq_op),
    .busy   (sq_busy),
    .done   (sq_done),
    .addend (sq_addend)
  );

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    acc_d   = acc_q;
    y_d     = y_q;
    sat_d   = sat_q;
    sum     = acc_q + sq_addend;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_a_d = magnitude(a);
          mag_b_d = magnitude(b);
          acc_d   = '0;
          state_d = MUL_A;
        end
      end
      MUL_A: begin
        acc_d = sum;
        if (sq_done) state_d = MUL_B;
      end
      MUL_B: begin
        acc_d = sum;
        // The final sum includes this cycle's partial product, so the
        // saturation decision is made on 'sum' rather than acc_q.
        if (sq_done) begin
          state_d = DONE;
          if (|sum[ACC_W-1:OUT_W]) begin
            y_d   = '1;
            sat_d = 1'b1;
          end else begin
            y_d   = sum[OUT_W-1:0];
            sat_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_dist_sq.sv
// Directed testbench for dist_sq: hand-computed sums of squares, latency,
// hold-under-backpressure, ignored inputs while busy, and reset mid-operation.
module tb_dist_sq;
  import dist_sq_pkg::*;

  localparam int W     = 11;
  localparam int OUT_W = 21;
  localparam int LAT   = 2 * W;
  localparam int BOUND = 60;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] a = '0;
  logic signed [W-1:0] b = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [OUT_W-1:0]    y;
  logic                sat;

  int total = 0;
  int bad   = 0;

  dist_sq #(.W(W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  // Single comparison point: every check in the bench goes through here.
  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offers one pair starting at a negedge, scrambles a/b after the accepting
  // edge, and returns the number of edges until out_valid plus how many
  // cycles in_ready was seen high while busy. Returns at a negedge.
  task automatic applyStimulus(input logic signed [W-1:0] av,
                               input logic signed [W-1:0] bv,
                               output int lat, output int ready_seen);
    lat        = 0;
    ready_seen = 0;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    while (!out_valid && lat < BOUND) begin
      if (in_ready) ready_seen++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [OUT_W-1:0] exp_y,
                             input logic exp_sat);
    check({tag, ".valid"}, longint'(out_valid), 1);
    check({tag, ".y"}, longint'(y), longint'(exp_y));
    check({tag, ".sat"}, longint'(sat), longint'(exp_sat));
  endtask

  // Runs one pair with out_ready=1, checks result and latency, then checks
  // that IDLE is back one cycle after the handshake.
  task automatic runPair(input string tag, input logic signed [W-1:0] av,
                         input logic signed [W-1:0] bv,
                         input logic [OUT_W-1:0] exp_y, input logic exp_sat);
    int lat, rs;
    applyStimulus(av, bv, lat, rs);
    check({tag, ".latency"}, lat, LAT);
    check({tag, ".busy_ready"}, rs, 0);
    checkOutput(tag, exp_y, exp_sat);
    check({tag, ".done_ready"}, longint'(in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".idle_ready"}, longint'(in_ready), 1);
    check({tag, ".idle_valid"}, longint'(out_valid), 0);
  endtask

  initial begin
    int lat, rs;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", longint'(in_ready), 1);
    check("rst.out_valid", longint'(out_valid), 0);
    check("rst.y", longint'(y), 0);
    check("rst.sat", longint'(sat), 0);
    rst = 1'b0;

    // First cycle after reset accepts immediately
    runPair("p3_4", 11'sd3, 11'sd4, 21'd25, 1'b0);
    runPair("pneg_0", -11'sd1024, 11'sd0, 21'd1048576, 1'b0);
    runPair("pneg_neg", -11'sd1024, -11'sd1024, SAT_MAX, 1'b1);
    runPair("p0_0", 11'sd0, 11'sd0, 21'd0, 1'b0);
    runPair("pmax_max", 11'sd1023, 11'sd1023, 21'd2093058, 1'b0);

    // Backpressure: result held, in_ready low, stray in_valid ignored
    out_ready = 1'b0;
    applyStimulus(11'sd7, -11'sd5, lat, rs);
    check("bp.latency", lat, LAT);
    checkOutput("bp", 21'd74, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      a        = 11'sd100;
      b        = 11'sd100;
      @(posedge clk);
      @(negedge clk);
      check("bp.hold_y", longint'(y), 74);
      check("bp.hold_valid", longint'(out_valid), 1);
      check("bp.hold_ready", longint'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp.resume_ready", longint'(in_ready), 1);
    check("bp.resume_valid", longint'(out_valid), 0);
    runPair("p1_2", 11'sd1, 11'sd2, 21'd5, 1'b0);

    // Reset in the middle of MUL_B discards the operation
    a        = 11'sd9;
    b        = 11'sd9;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("mid.valid_before", longint'(out_valid), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid.in_ready", longint'(in_ready), 1);
    check("mid.out_valid", longint'(out_valid), 0);
    check("mid.y", longint'(y), 0);
    check("mid.sat", longint'(sat), 0);
    runPair("p6_8", 11'sd6, 11'sd8, 21'd100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
